// File: rtl/pcie_stim_gen_if.sv
// pcie_stim_gen_if
//  Bundle of the signals exchanged between the stimulus sequencer and the
//  two PCIE trans DUT instances (conductual "_c" and synthesized "_s").
//  Parameters:
//   DATA_W  width of dut_data
//   N_DEST  destination count (width of dut_pop and data_out_*)
//  Modports:
//   master  sequencer side: drives dut_* strobes/data, samples DUT outputs
//   slave   DUT side: samples dut_* strobes/data, drives its outputs
interface pcie_stim_gen_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned N_DEST = 2
);
    logic              dut_reset_L;
    logic              dut_init;
    logic              dut_push;
    logic [DATA_W-1:0] dut_data;
    logic [N_DEST-1:0] dut_pop;

    logic              active_s;
    logic              active_c;
    logic              error_s;
    logic              error_c;
    logic              idle_s;
    logic              idle_c;
    logic [N_DEST-1:0] data_out_s;
    logic [N_DEST-1:0] data_out_c;

    modport master (
        output dut_reset_L, dut_init, dut_push, dut_data, dut_pop,
        input  active_s, active_c, error_s, error_c, idle_s, idle_c,
               data_out_s, data_out_c
    );

    modport slave (
        input  dut_reset_L, dut_init, dut_push, dut_data, dut_pop,
        output active_s, active_c, error_s, error_c, idle_s, idle_c,
               data_out_s, data_out_c
    );
endinterface

// File: rtl/pcie_stim_gen.sv
// pcie_stim_gen
//  Stimulus sequencer and dual-DUT checker for the PCIE trans block.
//  Runs IDLE -> RST -> INIT -> WAIT -> PUSH -> DRAIN -> DONE -> IDLE on a
//  start pulse, driving reset/init/push/data/pop to both DUTs, and compares
//  the synthesized and conductual DUT outputs every cycle from INIT to DONE.
//  All DUT-facing outputs are registered from the current state, so a value
//  belonging to state S appears the cycle after S is entered.
//  Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         one-cycle pulse, launches a run when idle
//   num_words     words to push in a run (0 skips PUSH), latched on start
//   bus           pcie_stim_gen_if.master: dut_* drive, DUT *_s/*_c sample
//   busy          run in progress
//   done          one-cycle pulse at end of run
//   mismatch      sticky compare-miss flag, cleared on start
//   mismatch_cnt  saturating count of compare-miss cycles
//   pushed_cnt    saturating count of pushes this run
//  Configuration macro:
//   STIM_LFSR_EN  payload from an 8-bit Fibonacci LFSR (taps 8,6,5,4)
//                 instead of the SEED+k counter
module pcie_stim_gen #(
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned N_DEST    = 2,
    parameter int unsigned RST_CYC   = 1,
    parameter int unsigned INIT_CYC  = 1,
    parameter int unsigned WAIT_CYC  = 3,
    parameter int unsigned DRAIN_CYC = 30,
    parameter logic [7:0]  SEED      = 8'h0B
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             num_words,
    pcie_stim_gen_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   mismatch,
    output logic [15:0]            mismatch_cnt,
    output logic [7:0]             pushed_cnt
);
    localparam int unsigned DEST_W = $clog2(N_DEST);
    localparam int unsigned PAY_W  = DATA_W - 1 - DEST_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RST   = 3'd1;
    localparam logic [2:0] S_INIT  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_PUSH  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [31:0]       cnt;
    logic [7:0]        nw_q;
    logic [DEST_W-1:0] dest_q;
    logic              vc_q;
    logic [N_DEST-1:0] pop_oh;
    logic [PAY_W-1:0]  payload;
    logic [DATA_W-1:0] word;

    logic              reset_l_q;
    logic              init_q;
    logic              push_q;
    logic [DATA_W-1:0] data_q;
    logic [N_DEST-1:0] pop_q;

    logic              cmp_en;
    logic              cmp_diff;

`ifdef STIM_LFSR_EN
    localparam logic [7:0] LFSR_SEED = (SEED == 8'h00) ? 8'h01 : SEED;
    logic [7:0] lfsr_q;
    assign payload = lfsr_q[PAY_W-1:0];
`else
    logic [PAY_W-1:0] pay_q;
    assign payload = pay_q;
`endif

    assign word = {vc_q, dest_q, payload};

    assign bus.dut_reset_L = reset_l_q;
    assign bus.dut_init    = init_q;
    assign bus.dut_push    = push_q;
    assign bus.dut_data    = data_q;
    assign bus.dut_pop     = pop_q;

    // Compare window covers INIT through DONE; IDLE and RST are excluded.
    assign cmp_en   = (state != S_IDLE) && (state != S_RST);
    assign cmp_diff = {bus.active_s, bus.error_s, bus.idle_s, bus.data_out_s}
                   != {bus.active_c, bus.error_c, bus.idle_c, bus.data_out_c};

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RST;
            S_RST:   if (cnt == RST_CYC - 1) state_nx = S_INIT;
            S_INIT:  if (cnt == INIT_CYC - 1) state_nx = S_WAIT;
            S_WAIT:  if (cnt == WAIT_CYC - 1)
                         state_nx = (nw_q == 8'd0) ? S_DRAIN : S_PUSH;
            S_PUSH:  if (cnt == {24'd0, nw_q} - 32'd1) state_nx = S_DRAIN;
            S_DRAIN: if (cnt == DRAIN_CYC - 1) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            nw_q         <= '0;
            dest_q       <= '0;
            vc_q         <= 1'b0;
            pop_oh       <= N_DEST'(1);
`ifdef STIM_LFSR_EN
            lfsr_q       <= LFSR_SEED;
`else
            pay_q        <= '0;
`endif
            reset_l_q    <= 1'b0;
            init_q       <= 1'b0;
            push_q       <= 1'b0;
            data_q       <= '0;
            pop_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
            pushed_cnt   <= '0;
        end else begin
            state <= state_nx;
            // Per-state cycle counter restarts from zero on every state entry.
            cnt   <= (state == S_IDLE || state_nx != state) ? '0 : cnt + 32'd1;

            reset_l_q <= (state != S_RST);
            init_q    <= (state == S_INIT);
            push_q    <= (state == S_PUSH);
            data_q    <= (state == S_PUSH) ? word : '0;
            pop_q     <= (state == S_DRAIN) ? pop_oh : '0;
            busy      <= (state != S_IDLE);
            done      <= (state == S_DONE);

            if (state == S_IDLE && start) begin
                nw_q         <= num_words;
                dest_q       <= '0;
                vc_q         <= 1'b0;
                pop_oh       <= N_DEST'(1);
`ifdef STIM_LFSR_EN
                lfsr_q       <= LFSR_SEED;
`else
                pay_q        <= SEED[PAY_W-1:0];
`endif
                pushed_cnt   <= '0;
                mismatch     <= 1'b0;
                mismatch_cnt <= '0;
            end

            if (state == S_PUSH) begin
                // dest walks 0..N_DEST-1; VC flips each time dest wraps.
                if (dest_q == DEST_W'(N_DEST - 1)) begin
                    dest_q <= '0;
                    vc_q   <= ~vc_q;
                end else begin
                    dest_q <= dest_q + DEST_W'(1);
                end
`ifdef STIM_LFSR_EN
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
                pay_q  <= pay_q + PAY_W'(1);
`endif
                if (pushed_cnt != 8'hFF) pushed_cnt <= pushed_cnt + 8'd1;
            end

            if (state == S_DRAIN) pop_oh <= {pop_oh[N_DEST-2:0], pop_oh[N_DEST-1]};

            if (cmp_en && cmp_diff) begin
                mismatch <= 1'b1;
                if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
            end
        end
    end
endmodule
